// File: rtl/per_req_arb_rr_if.sv
// Request/grant bus with per-lane payload. The upstream side uses NUM_CH lanes,
// the downstream side a single lane.
interface per_req_arb_rr_if #(
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned ID_WIDTH   = 20,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
    logic [NUM_CH-1:0]                 req;
    logic [NUM_CH-1:0]                 gnt;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] add;
    logic [NUM_CH-1:0]                 wen;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] wdata;
    logic [NUM_CH-1:0][BE_WIDTH-1:0]   be;
    logic [NUM_CH-1:0][ID_WIDTH-1:0]   id;

    modport master (output req, add, wen, wdata, be, id, input gnt);
    modport slave  (input req, add, wen, wdata, be, id, output gnt);
endinterface

// File: rtl/per_req_arb_rr.sv
// Round-robin arbiter of NUM_CH request channels onto one downstream port,
// with an optional single-entry registered output stage.
module per_req_arb_rr #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ID_WIDTH   = 20,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter bit          OUT_REG    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    per_req_arb_rr_if.slave  io_up,
    per_req_arb_rr_if.master io_dn
);
    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IW    = PTR_W + 1;

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_win;
    logic [IW-1:0]         w_idx;
    logic                  w_found;
    logic                  w_any;
    logic                  w_ld;
    logic [ADDR_WIDTH-1:0] w_sel_add;
    logic                  w_sel_wen;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [BE_WIDTH-1:0]   w_sel_be;
    logic [ID_WIDTH-1:0]   w_sel_id;

    assign w_any = |io_up.req;

    // Cyclic search starting at r_ptr; w_idx never exceeds 2*NUM_CH-2.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_ptr} + IW'(i);
            if (w_idx >= IW'(NUM_CH)) begin
                w_idx = w_idx - IW'(NUM_CH);
            end
            if (!w_found && io_up.req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_sel_add   = io_up.add[w_win];
    assign w_sel_wen   = io_up.wen[w_win];
    assign w_sel_wdata = io_up.wdata[w_win];
    assign w_sel_be    = io_up.be[w_win];
    assign w_sel_id    = io_up.id[w_win];

    always_comb begin
        io_up.gnt = '0;
        if (w_ld) begin
            io_up.gnt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_ld) begin
            r_ptr <= (w_win == PTR_W'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
        end
    end

    if (OUT_REG) begin : g_reg
        logic                  r_valid;
        logic [ADDR_WIDTH-1:0] r_add;
        logic                  r_wen;
        logic [DATA_WIDTH-1:0] r_wdata;
        logic [BE_WIDTH-1:0]   r_be;
        logic [ID_WIDTH-1:0]   r_id;

        // Load when empty or when the held entry drains this cycle.
        assign w_ld = w_any & (~r_valid | io_dn.gnt[0]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_add   <= '0;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_be    <= '0;
                r_id    <= '0;
            end else if (w_ld) begin
                r_valid <= 1'b1;
                r_add   <= w_sel_add;
                r_wen   <= w_sel_wen;
                r_wdata <= w_sel_wdata;
                r_be    <= w_sel_be;
                r_id    <= w_sel_id;
            end else if (io_dn.gnt[0]) begin
                r_valid <= 1'b0;
            end
        end

        assign io_dn.req   = r_valid;
        assign io_dn.add   = r_add;
        assign io_dn.wen   = r_wen;
        assign io_dn.wdata = r_wdata;
        assign io_dn.be    = r_be;
        assign io_dn.id    = r_id;
    end else begin : g_comb
        assign w_ld        = w_any & io_dn.gnt[0];
        assign io_dn.req   = w_any;
        assign io_dn.add   = w_any ? w_sel_add   : '0;
        assign io_dn.wen   = w_any ? w_sel_wen   : 1'b0;
        assign io_dn.wdata = w_any ? w_sel_wdata : '0;
        assign io_dn.be    = w_any ? w_sel_be    : '0;
        assign io_dn.id    = w_any ? w_sel_id    : '0;
    end

    logic w_unused;
    assign w_unused = w_found;
endmodule

// File: tb/tb_per_req_arb_rr.sv
// Bench for per_req_arb_rr: six instances (several NUM_CH / OUT_REG mixes),
// each checked every cycle against a queue-based reference model.
module tb_per_req_arb_rr;
    localparam int NINST = 6;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [19:0] id;
    } pay_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] t_req [NINST];
    logic       t_gnt [NINST];
    pay_t       t_pay [NINST][8];
    logic       t_done;

    logic [7:0] o_gnt [NINST];
    logic       o_req [NINST];
    pay_t       o_pay [NINST];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int unsigned NC = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 4 :
                                     (g == 3) ? 2 : (g == 4) ? 5 : 8;
        localparam bit OR = !(g == 2 || g == 4);

        per_req_arb_rr_if #(.NUM_CH(NC)) up_if ();
        per_req_arb_rr_if #(.NUM_CH(1))  dn_if ();

        per_req_arb_rr #(
            .NUM_CH    (NC),
            .ID_WIDTH  (20),
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .BE_WIDTH  (4),
            .OUT_REG   (OR)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .io_up(up_if.slave),
            .io_dn(dn_if.master)
        );

        assign up_if.req = t_req[g][NC-1:0];
        for (genvar c = 0; c < NC; c++) begin : g_ch
            assign up_if.add[c]   = t_pay[g][c].add;
            assign up_if.wen[c]   = t_pay[g][c].wen;
            assign up_if.wdata[c] = t_pay[g][c].wdata;
            assign up_if.be[c]    = t_pay[g][c].be;
            assign up_if.id[c]    = t_pay[g][c].id;
        end
        assign dn_if.gnt = t_gnt[g];
        assign o_gnt[g]  = 8'(up_if.gnt);
        assign o_req[g]  = dn_if.req[0];
        assign o_pay[g]  = {dn_if.add[0], dn_if.wen[0], dn_if.wdata[0], dn_if.be[0],
                            dn_if.id[0]};

        // Reference: pointer as an integer, output stage as a FIFO of granted payloads.
        initial begin : model
            int unsigned ptr;
            int unsigned w;
            int unsigned waitc [8];
            pay_t        q [$];
            pay_t        got;
            logic [7:0]  req;
            logic [7:0]  eg;
            bit          any, ld, gi, ereq, found, done_chk;
            ptr = 0;
            done_chk = 1'b0;
            for (int i = 0; i < 8; i++) waitc[i] = 0;
            forever begin
                @(negedge clk);
                #2;
                req = t_req[g] & 8'((9'd1 << NC) - 9'd1);
                gi  = t_gnt[g];
                got = o_pay[g];
                if (!rst_n) begin
                    ptr = 0;
                    q.delete();
                    for (int i = 0; i < 8; i++) waitc[i] = 0;
                    chk($sformatf("i%0d rst req_o", g), o_req[g], 0);
                    chk($sformatf("i%0d rst gnt_o", g), o_gnt[g], 0);
                    if (OR) chk($sformatf("i%0d rst payload", g), got, 0);
                end else begin
                    any = |req;
                    w = 0;
                    found = 1'b0;
                    for (int i = 0; i < NC; i++) begin
                        if (!found && req[(ptr + i) % NC]) begin
                            found = 1'b1;
                            w = (ptr + i) % NC;
                        end
                    end
                    if (OR) begin
                        ereq = q.size() != 0;
                        ld   = any && (q.size() == 0 || gi);
                    end else begin
                        ereq = any;
                        ld   = any && gi;
                    end
                    eg = ld ? 8'(1 << w) : 8'h00;
                    chk($sformatf("i%0d gnt_o", g), o_gnt[g], eg);
                    chk($sformatf("i%0d req_o", g), o_req[g], ereq);
                    if (!OR && !any) chk($sformatf("i%0d idle payload", g), got, 0);
                    if (OR && ereq) begin
                        chk($sformatf("i%0d held payload", g), got, q[0]);
                        if (gi) void'(q.pop_front());
                    end
                    if (ld) begin
                        chk($sformatf("i%0d starve ch%0d", g, w), waitc[w] < NC, 1);
                        q.push_back(t_pay[g][w]);
                        ptr = (w + 1) % NC;
                        for (int k = 0; k < NC; k++) begin
                            if (k == w || !req[k]) waitc[k] = 0;
                            else waitc[k]++;
                        end
                    end else begin
                        for (int k = 0; k < NC; k++) if (!req[k]) waitc[k] = 0;
                    end
                    if (!OR && ld) begin
                        chk($sformatf("i%0d comb payload", g), got, q[0]);
                        void'(q.pop_front());
                    end
                    if (t_done && !done_chk) begin
                        done_chk = 1'b1;
                        chk($sformatf("i%0d leftover", g), q.size(), 0);
                    end
                end
            end
        end
    end

    task automatic set_dir_pay();
        for (int g = 0; g < NINST; g++) begin
            for (int c = 0; c < 8; c++) begin
                t_pay[g][c].add   = 32'(c + 1) << 28;
                t_pay[g][c].wen   = c[0];
                t_pay[g][c].wdata = 32'hD000_0000 + 32'(c);
                t_pay[g][c].be    = 4'(c + 1);
                t_pay[g][c].id    = 20'(16 * (g + 1) + c);
            end
        end
    endtask

    task automatic idle_all(input logic gi);
        for (int g = 0; g < NINST; g++) begin
            t_req[g] = 8'h00;
            t_gnt[g] = gi;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        t_done = 1'b0;
        idle_all(1'b0);
        set_dir_pay();
        repeat (3) @(negedge clk);
        #3;
        chk("reset req_o", o_req[0], 0);
        chk("reset add_o", o_pay[0].add, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("post-reset req_o", o_req[0], 0);
        chk("post-reset gnt_o", o_gnt[0], 0);

        // Four channels all requesting, downstream always ready.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            t_req[0] = 8'h0F;
            t_gnt[0] = 1'b1;
            #3;
            chk($sformatf("rr gnt k%0d", k), o_gnt[0], 8'(1 << (k % 4)));
            chk($sformatf("rr req_o k%0d", k), o_req[0], k >= 1);
            if (k >= 1) chk($sformatf("rr ID_o k%0d", k), o_pay[0].id, 20'h10 + 20'((k - 1) % 4));
        end
        @(negedge clk);
        idle_all(1'b0);
        t_gnt[0] = 1'b1;

        // Downstream stall holds the registered entry.
        @(negedge clk);
        t_gnt[0] = 1'b0;
        t_req[0] = 8'b0010;
        #3;
        chk("stall load gnt", o_gnt[0], 8'b0010);
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            t_pay[0][1].add = 32'h2222_0000;
            #3;
            chk($sformatf("stall gnt m%0d", m), o_gnt[0], 0);
            chk($sformatf("stall add m%0d", m), o_pay[0].add, 32'h2000_0000);
        end
        @(negedge clk);
        t_gnt[0] = 1'b1;
        #3;
        chk("release gnt", o_gnt[0], 8'b0010);
        chk("release add", o_pay[0].add, 32'h2000_0000);
        @(negedge clk);
        t_req[0] = 8'h00;
        t_gnt[0] = 1'b0;
        #3;
        chk("new payload", o_pay[0].add, 32'h2222_0000);
        @(negedge clk);
        t_req[0] = 8'b0001;
        t_gnt[0] = 1'b1;
        #3;
        chk("swap gnt", o_gnt[0], 8'b0001);
        @(negedge clk);
        t_req[0] = 8'h00;
        t_gnt[0] = 1'b0;
        #3;
        chk("pre-reset add", o_pay[0].add, 32'h1000_0000);
        chk("pre-reset req", o_req[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        chk("async reset req", o_req[0], 0);
        chk("async reset add", o_pay[0].add, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("discard req", o_req[0], 0);
        chk("discard gnt", o_gnt[0], 0);
        @(negedge clk);
        t_req[0] = 8'h0F;
        t_gnt[0] = 1'b1;
        #3;
        chk("ptr reset", o_gnt[0], 8'b0001);
        @(negedge clk);
        idle_all(1'b1);
        set_dir_pay();

        // Three channels: wrap from channel 2 back to 0.
        @(negedge clk);
        t_req[1] = 8'b001;
        #3;
        chk("n3 first", o_gnt[1], 8'b001);
        @(negedge clk);
        t_req[1] = 8'b101;
        #3;
        chk("n3 from ptr1", o_gnt[1], 8'b100);
        @(negedge clk);
        #3;
        chk("n3 wrap", o_gnt[1], 8'b001);
        @(negedge clk);
        idle_all(1'b1);

        // Combinational variant.
        @(negedge clk);
        idle_all(1'b0);
        t_req[2] = 8'b0100;
        #3;
        chk("comb no gnt", o_gnt[2], 0);
        chk("comb req_o", o_req[2], 1);
        chk("comb add_o", o_pay[2].add, 32'h3000_0000);
        @(negedge clk);
        t_gnt[2] = 1'b1;
        #3;
        chk("comb gnt", o_gnt[2], 8'b0100);
        @(negedge clk);
        t_req[2] = 8'h0F;
        #3;
        chk("comb ptr3", o_gnt[2], 8'b1000);
        @(negedge clk);
        idle_all(1'b0);
        #3;
        chk("comb idle req", o_req[2], 0);
        chk("comb idle add", o_pay[2].add, 0);

        // Random regression on every instance.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < NINST; g++) begin
                for (int c = 0; c < 8; c++) begin
                    if (t_req[g][c]) t_req[g][c] = ($urandom_range(7) != 0);
                    else t_req[g][c] = ($urandom_range(2) == 0);
                    t_pay[g][c].add   = $urandom;
                    t_pay[g][c].wen   = 1'($urandom);
                    t_pay[g][c].wdata = $urandom;
                    t_pay[g][c].be    = 4'($urandom);
                    t_pay[g][c].id    = {16'(cyc), 4'(c)};
                end
                t_gnt[g] = ($urandom_range(9) < 6);
            end
        end
        @(negedge clk);
        idle_all(1'b1);
        repeat (3) @(negedge clk);
        t_done = 1'b1;
        repeat (2) @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
